// File: rtl/dp_neuron_sequencer_pkg.sv
// dp_neuron_sequencer_pkg: shared state encoding and width helper for the neuron sequencer
//   state_t : IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE
//   clog2   : ceiling log2, used to size counters and check IDX_W
package dp_neuron_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dp_neuron_sequencer_relu_sat.sv
// dp_neuron_sequencer_relu_sat: combinational bias add with positive saturation and ReLU
//   a, b : signed VAL_SIZE operands (dot-product value and bias)
//   y    : clamp(a + b, 0, 2**(VAL_SIZE-1)-1)
module dp_neuron_sequencer_relu_sat #(
  parameter int VAL_SIZE = 26
) (
  input  logic [VAL_SIZE-1:0] a,
  input  logic [VAL_SIZE-1:0] b,
  output logic [VAL_SIZE-1:0] y
);
  localparam logic [VAL_SIZE-1:0] MAX_POS = {1'b0, {(VAL_SIZE-1){1'b1}}};
  logic [VAL_SIZE:0] sum;
  assign sum = {a[VAL_SIZE-1], a} + {b[VAL_SIZE-1], b};
  // sign bit set -> negative -> 0; otherwise bit VAL_SIZE-1 set means the sum left the positive range
  assign y = sum[VAL_SIZE] ? '0 : sum[VAL_SIZE-1] ? MAX_POS : sum[VAL_SIZE-1:0];
endmodule

// File: rtl/dp_neuron_sequencer.sv
// dp_neuron_sequencer: drives the dot-product stage per neuron, applies bias+ReLU and tracks argmax
//   start            : begin a run (IDLE only)
//   dp_value/bias_in : dot-product sum and bias of neuron_idx, sampled in CAPTURE
//   dp_clr/feed_en   : clear pulse and feed window to the dot-product stage
//   act_value/valid  : activation of the last captured neuron
//   best_idx/value   : running argmax; done pulses when final; busy outside IDLE
module dp_neuron_sequencer
  import dp_neuron_sequencer_pkg::*;
#(
  parameter int VAL_SIZE     = 26,
  parameter int NEURON_N     = 10,
  parameter int FEED_CYCLES  = 5,
  parameter int DRAIN_CYCLES = 12,
  parameter int IDX_W        = 4
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic                start,
  input  logic [VAL_SIZE-1:0] dp_value,
  input  logic [VAL_SIZE-1:0] bias_in,
  output logic                dp_clr,
  output logic                feed_en,
  output logic [IDX_W-1:0]    neuron_idx,
  output logic [VAL_SIZE-1:0] act_value,
  output logic                act_valid,
  output logic [IDX_W-1:0]    best_idx,
  output logic [VAL_SIZE-1:0] best_value,
  output logic                done,
  output logic                busy
);
  localparam int CNT_W = clog2((FEED_CYCLES > DRAIN_CYCLES ? FEED_CYCLES : DRAIN_CYCLES) + 1);
  if (IDX_W < clog2(NEURON_N)) begin : g_idx_chk
    $error("IDX_W too narrow for NEURON_N");
  end
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, best_idx_q, best_idx_d;
  logic [VAL_SIZE-1:0] act_q, act_d, best_q, best_d, act_w;
  logic clr_q, clr_d, feed_q, feed_d, act_valid_q, act_valid_d, done_q, done_d, busy_q, busy_d;
  logic last;
  dp_neuron_sequencer_relu_sat #(.VAL_SIZE(VAL_SIZE)) u_relu (.a(dp_value), .b(bias_in), .y(act_w));
  assign last = idx_q == IDX_W'(NEURON_N - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    act_d = act_q;
    best_d = best_q;
    best_idx_d = best_idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        idx_d = '0;
      end
      CLEAR: begin
        state_d = FEED;
        cnt_d = CNT_W'(FEED_CYCLES - 1);
      end
      FEED: begin
        state_d = cnt_q == '0 ? DRAIN : FEED;
        cnt_d = cnt_q == '0 ? CNT_W'(DRAIN_CYCLES - 1) : cnt_q - 1'b1;
      end
      DRAIN: begin
        state_d = cnt_q == '0 ? CAPTURE : DRAIN;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      CAPTURE: begin
        act_d = act_w;
        // first neuron of a run overwrites the previous run's winner; strict > keeps the lower index on ties
        if (idx_q == '0 || $signed(act_w) > $signed(best_q)) begin
          best_d = act_w;
          best_idx_d = idx_q;
        end
        state_d = last ? DONE : CLEAR;
        idx_d = last ? idx_q : idx_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
    clr_d = state_d == CLEAR;
    feed_d = state_d == FEED;
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
    act_valid_d = state_q == CAPTURE;
  end
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      act_q <= '0;
      best_q <= '0;
      best_idx_q <= '0;
      clr_q <= 1'b0;
      feed_q <= 1'b0;
      act_valid_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      act_q <= act_d;
      best_q <= best_d;
      best_idx_q <= best_idx_d;
      clr_q <= clr_d;
      feed_q <= feed_d;
      act_valid_q <= act_valid_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign dp_clr = clr_q;
  assign feed_en = feed_q;
  assign neuron_idx = idx_q;
  assign act_value = act_q;
  assign act_valid = act_valid_q;
  assign best_idx = best_idx_q;
  assign best_value = best_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule
